// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes immediately with an all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // One restoring step; prem carries an extra bit so the compare cannot overflow.
  logic [WIDTH:0]   prem_sh, prem_nx;
  logic [WIDTH-1:0] qsh_nx;
  logic             fits;

  always_comb begin
    prem_sh = {prem_q[WIDTH-1:0], qsh_q[WIDTH-1]};
    fits    = (prem_sh >= {1'b0, dvsr_q});
    prem_nx = fits ? (prem_sh - {1'b0, dvsr_q}) : prem_sh;
    qsh_nx  = {qsh_q[WIDTH-2:0], fits};
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    qsh_d   = qsh_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          dvsr_d = divisor;
          qsh_d  = dividend;
          prem_d = '0;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = CW'(WIDTH - 1);
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        prem_d = prem_nx;
        qsh_d  = qsh_nx;
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = qsh_nx;
          rem_d   = prem_nx[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      qsh_q   <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      qsh_q   <= qsh_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=5): directed cases, reset abort, exhaustive back-to-back sweep.
module tb_seq_divider;

  localparam int W = 5;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   pushed   = 0;
  exp_t sb[$];
  exp_t mon_e;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    sb.push_back(model(a, b));
    pushed++;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", quotient, mon_e.q);
        check("remainder", remainder, mon_e.r);
        check("div_by_zero", div_by_zero, mon_e.dbz);
      end
    end
  end

  // Called at a negedge with the DUT idle or in DONE; returns one negedge after done.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input int exp_busy);
    int n = 0;
    int nbusy = 0;
    bit got = 0;
    start = 1'b1; dividend = a; divisor = b;
    push(a, b);
    while (!got && n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nbusy++;
      if (done) got = 1;
    end
    check({tag, "_latency"}, got ? n : -1, exp_lat);
    check({tag, "_busy_cycles"}, nbusy, exp_busy);
    @(negedge clk);
    check({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    int d0;
    int guard;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("d27_4", 5'd27, 5'd4, W + 1, W);
    repeat (3) @(negedge clk);
    check("hold_quotient", quotient, 6);
    check("hold_remainder", remainder, 3);

    run_one("d31_1", 5'd31, 5'd1, W + 1, W);
    run_one("d3_7", 5'd3, 5'd7, W + 1, W);
    run_one("d0_5", 5'd0, 5'd5, W + 1, W);
    run_one("d31_31", 5'd31, 5'd31, W + 1, W);

    run_one("d9_0", 5'd9, 5'd0, 1, 0);
    check("dbz_held", div_by_zero, 1);
    check("dbz_quotient_held", quotient, 31);
    run_one("d10_3", 5'd10, 5'd3, W + 1, W);

    // A second start while busy must be ignored.
    d0 = done_cnt;
    start = 1'b1; dividend = 5'd20; divisor = 5'd3;
    push(5'd20, 5'd3);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    @(negedge clk);
    start = 1'b1; dividend = 5'd7; divisor = 5'd7;
    @(negedge clk);
    start = 1'b0;
    check("hold_during_calc", quotient, 3);
    repeat (8) @(negedge clk);
    check("ignored_start_dones", done_cnt - d0, 1);

    // Reset in the middle of CALC aborts without a done pulse.
    d0 = done_cnt;
    start = 1'b1; dividend = 5'd25; divisor = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_one("d15_2", 5'd15, 5'd2, W + 1, W);

    // Exhaustive sweep with start held high; each idle negedge means the next edge accepts.
    start = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        dividend = W'(a); divisor = W'(b);
        push(W'(a), W'(b));
        @(negedge clk);
        guard = 0;
        while (busy && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 20) check("sweep_timeout", 0, 1);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", done_cnt, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
